// File: rtl/div_hilo_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_hilo_unit_pkg
//  Purpose  : Shared width and FSM state encodings for the HI/LO divider.
//  Contents : DIV_WIDTH       - default operand/result width
//             div_state_t     - 2-bit divider control state
//  Revision : 1.0 - initial release
// ============================================================================
package div_hilo_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE  = 2'd0,
        DIV_RUN   = 2'd1,
        DIV_DZERO = 2'd2,
        DIV_DONE  = 2'd3
    } div_state_t;

endpackage : div_hilo_unit_pkg
`default_nettype wire

// File: rtl/div_hilo_unit_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_hilo_unit_step
//  Purpose  : One combinational restoring-division step. Shifts {rem,quo}
//             left by one (next dividend bit enters rem from quo's MSB),
//             subtracts the divisor when it fits and shifts the resulting
//             quotient bit into quo's LSB.
//  Ports    : rem       in  WIDTH  partial remainder
//             quo       in  WIDTH  remaining dividend bits / quotient bits
//             divisor   in  WIDTH  divisor magnitude
//             rem_next  out WIDTH  partial remainder after this step
//             quo_next  out WIDTH  shifted quotient register after this step
//  Revision : 1.0 - initial release
// ============================================================================
module div_hilo_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // rem < divisor always holds, so w_shift < 2*divisor and the difference
    // lies in (-2^WIDTH, 2^WIDTH): bit WIDTH of the difference is its sign.
    assign w_shift  = {rem, quo[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, divisor};
    assign w_ge     = ~w_diff[WIDTH];

    assign rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign quo_next = {quo[WIDTH-2:0], w_ge};

endmodule : div_hilo_unit_step
`default_nettype wire

// File: rtl/div_hilo_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_hilo_unit
//  Purpose  : Iterative signed/unsigned divider producing HI/LO write data
//             for DIV/DIVU in the EX stage. Holds the pipeline via stall_req
//             while running and pulses done for one cycle with the result.
//  Ports    : clk         in  1      rising-edge clock
//             rst         in  1      synchronous active-high reset
//             start       in  1      begin a division (sampled in IDLE only)
//             signed_div  in  1      1 = DIV, 0 = DIVU
//             flush       in  1      abort current operation
//             dividend    in  WIDTH  rs operand
//             divisor     in  WIDTH  rt operand
//             stall_req   out 1      pipeline hold while division in progress
//             done        out 1      one-cycle result-valid pulse
//             quotient    out WIDTH  LO write data
//             remainder   out WIDTH  HI write data
//  Revision : 1.0 - initial release
// ============================================================================
module div_hilo_unit
    import div_hilo_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    div_state_t         r_state;
    div_state_t         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;

    logic               w_load;
    logic               w_step;
    logic               w_finish_run;
    logic               w_finish_zero;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;
    logic [WIDTH-1:0]   w_dividend_mag;
    logic [WIDTH-1:0]   w_divisor_mag;

    // Operand magnitudes; -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the
    // correct unsigned magnitude and yields the no-trap overflow result.
    assign w_dividend_mag = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_divisor_mag  = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;

    div_hilo_unit_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .divisor  (r_dvs),
        .rem_next (w_rem_next),
        .quo_next (w_quo_next)
    );

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and outputs. Flush overrides every state and
    // suppresses stall_req/done in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        stall_req     = 1'b0;
        done          = 1'b0;
        w_load        = 1'b0;
        w_step        = 1'b0;
        w_finish_run  = 1'b0;
        w_finish_zero = 1'b0;
        if (flush) begin
            w_state_next = DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        stall_req    = 1'b1;
                        w_load       = 1'b1;
                        w_state_next = (divisor == '0) ? DIV_DZERO : DIV_RUN;
                    end
                end
                DIV_DZERO: begin
                    stall_req     = 1'b1;
                    w_finish_zero = 1'b1;
                    w_state_next  = DIV_DONE;
                end
                DIV_RUN: begin
                    stall_req = 1'b1;
                    w_step    = 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_finish_run = 1'b1;
                        w_state_next = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    done         = 1'b1;
                    w_state_next = DIV_IDLE;
                end
                default: begin
                    w_state_next = DIV_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, iteration and sign fix-up. The result is
    // registered on the edge entering DONE so it is stable while done=1.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            if (w_load) begin
                r_cnt   <= '0;
                r_rem   <= '0;
                r_quo   <= w_dividend_mag;
                r_dvs   <= w_divisor_mag;
                r_neg_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg_r <= signed_div & dividend[WIDTH-1];
            end else if (w_step) begin
                r_cnt <= r_cnt + c_CNT_ONE;
                r_rem <= w_rem_next;
                r_quo <= w_quo_next;
            end

            if (w_finish_run) begin
                r_quotient  <= r_neg_q ? -w_quo_next : w_quo_next;
                r_remainder <= r_neg_r ? -w_rem_next : w_rem_next;
            end else if (w_finish_zero) begin
                r_quotient  <= '0;
                r_remainder <= '0;
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule : div_hilo_unit
`default_nettype wire

// File: tb/tb_div_hilo_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_div_hilo_unit
//  Purpose  : Directed self-checking bench for div_hilo_unit. Inputs change
//             and outputs are sampled on the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_hilo_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        flush;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        stall_req;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int stall_bad;

    always #5 clk = ~clk;

    div_hilo_unit #(
        .WIDTH      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .flush      (flush),
        .dividend   (dividend),
        .divisor    (divisor),
        .stall_req  (stall_req),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called right after a falling edge. Drives start (cycle 0), then walks
    // cycles until done or the bound. lat = cycle index of done, -1 if none.
    // stall_bad counts cycles before done where stall_req was low.
    // disturb=1 re-pulses start and toggles the operands in RUN cycle 5.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic disturb, output int l, output int sb);
        start      = 1'b1;
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        sb         = 0;
        l          = -1;
        #1;
        if (stall_req !== 1'b1) sb++;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (done === 1'b1) begin
                l = c;
                break;
            end
            if (stall_req !== 1'b1) sb++;
            if (disturb && c == 5) begin
                start      = 1'b1;
                signed_div = ~sgn;
                dividend   = ~a;
                divisor    = 32'd3;
            end
            if (disturb && c == 6) begin
                start    = 1'b0;
                dividend = 32'd12345;
                divisor  = 32'd0;
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        flush      = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("reset_stall", {31'd0, stall_req}, 32'd0);
        chk("reset_done",  {31'd0, done},      32'd0);
        chk("reset_quot",  quotient,           32'd0);
        chk("reset_rem",   remainder,          32'd0);

        // 1. DIVU 100/7
        @(negedge clk);
        run_div(1'b0, 32'd100, 32'd7, 1'b0, lat, stall_bad);
        chk("divu100_7_latency", lat,            32'd33);
        chk("divu100_7_stall",   stall_bad,      32'd0);
        chk("divu100_7_stall_at_done", {31'd0, stall_req}, 32'd0);
        chk("divu100_7_quot",    quotient,       32'd14);
        chk("divu100_7_rem",     remainder,      32'd2);
        @(negedge clk);
        chk("divu100_7_done_one_cycle", {31'd0, done}, 32'd0);
        chk("divu100_7_quot_held", quotient, 32'd14);

        // 2. Signed rounding toward zero, remainder follows dividend
        @(negedge clk);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, stall_bad);
        chk("div_m7_2_latency", lat,       32'd33);
        chk("div_m7_2_quot",    quotient,  32'hFFFF_FFFD);
        chk("div_m7_2_rem",     remainder, 32'hFFFF_FFFF);
        @(negedge clk);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, lat, stall_bad);
        chk("div_7_m2_quot",    quotient,  32'hFFFF_FFFD);
        chk("div_7_m2_rem",     remainder, 32'd1);

        // 3. Overflow and unsigned extremes
        @(negedge clk);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, stall_bad);
        chk("div_ovf_quot", quotient,  32'h8000_0000);
        chk("div_ovf_rem",  remainder, 32'd0);
        @(negedge clk);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, lat, stall_bad);
        chk("divu_max_1_quot", quotient,  32'hFFFF_FFFF);
        chk("divu_max_1_rem",  remainder, 32'd0);
        @(negedge clk);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, stall_bad);
        chk("divu_8000_ffff_quot", quotient,  32'd0);
        chk("divu_8000_ffff_rem",  remainder, 32'h8000_0000);

        // 4. Divide by zero
        @(negedge clk);
        run_div(1'b1, 32'd55, 32'd0, 1'b0, lat, stall_bad);
        chk("dzero_latency", lat,       32'd2);
        chk("dzero_stall",   stall_bad, 32'd0);
        chk("dzero_quot",    quotient,  32'd0);
        chk("dzero_rem",     remainder, 32'd0);

        // 5. Flush at RUN cycle 10, then immediate restart with 20/3
        @(negedge clk);
        start    = 1'b1;
        signed_div = 1'b0;
        dividend = 32'd1000;
        divisor  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_stall_drop", {31'd0, stall_req}, 32'd0);
        chk("flush_no_done",    {31'd0, done},      32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle_after", {31'd0, stall_req}, 32'd0);
        run_div(1'b0, 32'd20, 32'd3, 1'b0, lat, stall_bad);
        chk("after_flush_latency", lat,       32'd33);
        chk("after_flush_stall",   stall_bad, 32'd0);
        chk("after_flush_quot",    quotient,  32'd6);
        chk("after_flush_rem",     remainder, 32'd2);

        // flush together with start in IDLE keeps the unit idle
        @(negedge clk);
        flush      = 1'b1;
        start      = 1'b1;
        dividend   = 32'd9;
        divisor    = 32'd0;
        #1;
        chk("flush_start_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        #1;
        chk("flush_start_stays_idle", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        chk("flush_start_no_done", {31'd0, done}, 32'd0);
        chk("flush_start_quot_kept", quotient, 32'd6);

        // 6a. start re-pulse and operand toggles mid-RUN: DIV -100/7
        @(negedge clk);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1, lat, stall_bad);
        chk("disturb_latency", lat,       32'd33);
        chk("disturb_stall",   stall_bad, 32'd0);
        chk("disturb_quot",    quotient,  32'hFFFF_FFF2);
        chk("disturb_rem",     remainder, 32'hFFFF_FFFE);

        // 6b. rst at RUN cycle 5
        @(negedge clk);
        start      = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_mid_done",  {31'd0, done},      32'd0);
        chk("rst_mid_quot",  quotient,           32'd0);
        chk("rst_mid_rem",   remainder,          32'd0);
        run_div(1'b0, 32'd100, 32'd7, 1'b0, lat, stall_bad);
        chk("after_rst_latency", lat,       32'd33);
        chk("after_rst_quot",    quotient,  32'd14);
        chk("after_rst_rem",     remainder, 32'd2);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_div_hilo_unit
`default_nettype wire
